// File: rtl/bp_fe_fetch_tracker.sv
// Tracks fixed-latency iTLB/icache fetches and keeps their results in order in a response queue.
// Latency: a fetch issued in cycle t is visible on resp_v_o in cycle t+latency_p; there is no bypass.
// Backpressure: issue is credit-gated (queued + in-flight < fifo_els_p), so a result never meets a full queue.
module bp_fe_fetch_tracker #(
  parameter int vaddr_width_p = 39,
  parameter int instr_width_p = 32,
  parameter int latency_p     = 2,
  parameter int fifo_els_p    = 4
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     cmd_v_i,
  input  logic [vaddr_width_p-1:0] cmd_vaddr_i,
  output logic                     cmd_yumi_o,
  output logic                     cache_v_o,
  input  logic                     cache_ready_i,
  input  logic [instr_width_p-1:0] cache_data_i,
  input  logic                     cache_data_v_i,
  input  logic                     itlb_miss_i,
  input  logic                     page_fault_i,
  input  logic                     access_fault_i,
  input  logic                     poison_i,
  input  logic                     flush_i,
  output logic                     resp_v_o,
  output logic [vaddr_width_p-1:0] resp_vaddr_o,
  output logic [instr_width_p-1:0] resp_data_o,
  output logic [2:0]               resp_type_o,
  input  logic                     resp_yumi_i
);

  localparam int credit_w_lp = $clog2(fifo_els_p + latency_p + 1);
  localparam int cnt_w_lp    = $clog2(fifo_els_p + 1);
  localparam int ptr_w_lp    = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  // The issue cycle is pipe stage 0; only the later stages need registers.
  localparam int stages_lp   = (latency_p > 1) ? latency_p - 1 : 1;

  typedef enum logic [2:0] {
    e_ok           = 3'd0,
    e_access_fault = 3'd1,
    e_page_fault   = 3'd2,
    e_itlb_miss    = 3'd3,
    e_icache_miss  = 3'd4
  } resp_type_e;

  typedef enum logic {e_run, e_wait} state_e;

  typedef struct packed {
    logic [vaddr_width_p-1:0] vaddr;
    logic [instr_width_p-1:0] data;
    resp_type_e               rtype;
  } resp_entry_s;

  state_e                   state_r;
  logic [stages_lp-1:0]     stage_v_r;
  logic [vaddr_width_p-1:0] stage_vaddr_r [stages_lp];
  resp_entry_s              queue_r [fifo_els_p];
  logic [ptr_w_lp-1:0]      wptr_r, rptr_r;
  logic [cnt_w_lp-1:0]      count_r;

  logic                     issue, enq, deq, exc, final_v, queue_empty, queue_full;
  logic [vaddr_width_p-1:0] final_vaddr;
  logic [credit_w_lp-1:0]   inflight, credits;
  resp_type_e               final_type;
  resp_entry_s              enq_entry, head;

  // Count fetches held in the registered pipe stages.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < stages_lp; i++) inflight = inflight + credit_w_lp'(stage_v_r[i]);
  end

  assign credits     = inflight + credit_w_lp'(count_r);
  assign queue_empty = (count_r == '0);
  assign queue_full  = (count_r == cnt_w_lp'(fifo_els_p));

  // Reset also gates issue so nothing is reported accepted while state is being cleared.
  assign issue = cmd_v_i & cache_ready_i & (state_r == e_run) & ~poison_i & ~flush_i & ~reset_i
               & (credits < credit_w_lp'(fifo_els_p));
  assign cmd_yumi_o = issue;
  assign cache_v_o  = issue;

  // With a single-cycle cache the issue cycle is itself the final stage.
  if (latency_p > 1) begin : g_piped
    assign final_v     = stage_v_r[stages_lp-1];
    assign final_vaddr = stage_vaddr_r[stages_lp-1];
  end else begin : g_direct
    assign final_v     = issue;
    assign final_vaddr = cmd_vaddr_i;
  end

  // Classify the final-stage result by fault priority; data is only kept on a clean hit.
  always_comb begin
    final_type = e_ok;
    if (access_fault_i)       final_type = e_access_fault;
    else if (page_fault_i)    final_type = e_page_fault;
    else if (itlb_miss_i)     final_type = e_itlb_miss;
    else if (!cache_data_v_i) final_type = e_icache_miss;
    enq_entry.vaddr = final_vaddr;
    enq_entry.rtype = final_type;
    enq_entry.data  = (final_type == e_ok) ? cache_data_i : '0;
  end

  assign enq = final_v & ~poison_i & ~flush_i;
  assign exc = enq & (final_type != e_ok);

  assign head         = queue_r[rptr_r];
  assign resp_v_o     = ~queue_empty & ~flush_i;
  assign resp_vaddr_o = head.vaddr;
  assign resp_data_o  = head.data;
  assign resp_type_o  = head.rtype;
  assign deq          = resp_v_o & resp_yumi_i;

  // Advance stage valids; poison, flush or an exception kills everything still in the pipe.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stage_v_r <= '0;
    end else if (poison_i | flush_i | exc) begin
      stage_v_r <= '0;
    end else begin
      stage_v_r[0] <= issue && (latency_p > 1);
      for (int i = 1; i < stages_lp; i++) stage_v_r[i] <= stage_v_r[i-1];
    end
  end

  // Stage addresses shift freely; only the valids decide whether they mean anything.
  always_ff @(posedge clk_i) begin
    stage_vaddr_r[0] <= cmd_vaddr_i;
    for (int i = 1; i < stages_lp; i++) stage_vaddr_r[i] <= stage_vaddr_r[i-1];
  end

  // Queue storage write at the tail.
  always_ff @(posedge clk_i) begin
    if (enq) queue_r[wptr_r] <= enq_entry;
  end

  // Queue pointers and occupancy; flush empties the queue regardless of enq/deq.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else if (flush_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (enq) wptr_r <= (wptr_r == ptr_w_lp'(fifo_els_p - 1)) ? '0 : wptr_r + ptr_w_lp'(1);
      if (deq) rptr_r <= (rptr_r == ptr_w_lp'(fifo_els_p - 1)) ? '0 : rptr_r + ptr_w_lp'(1);
      case ({enq, deq})
        2'b10:   count_r <= count_r + cnt_w_lp'(1);
        2'b01:   count_r <= count_r - cnt_w_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Stall after any exception until the front end redirects with a flush.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)      state_r <= e_run;
    else if (flush_i) state_r <= e_run;
    else if (exc)     state_r <= e_wait;
  end

  a_yumi_only_with_v: assert property (@(posedge clk_i) disable iff (reset_i)
    resp_yumi_i |-> (resp_v_o || flush_i));
  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(enq && queue_full && !deq));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(deq && queue_empty));

endmodule

// File: tb/tb_bp_fe_fetch_tracker.sv
// Bench for bp_fe_fetch_tracker: directed scenarios plus random traffic against a transaction model.
// Latency: model predicts each cycle's issue/response outputs from queues of fetch records.
// Backpressure: consumer yumi is only offered when a response is expected (or alongside flush).
module tb_bp_fe_fetch_tracker;

  localparam int VA   = 39;
  localparam int IW   = 32;
  localparam int LAT  = 2;
  localparam int FIFO = 4;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          cmd_v_i;
  logic [VA-1:0] cmd_vaddr_i;
  logic          cmd_yumi_o, cache_v_o, cache_ready_i;
  logic [IW-1:0] cache_data_i;
  logic          cache_data_v_i, itlb_miss_i, page_fault_i, access_fault_i, poison_i, flush_i;
  logic          resp_v_o;
  logic [VA-1:0] resp_vaddr_o;
  logic [IW-1:0] resp_data_o;
  logic [2:0]    resp_type_o;
  logic          resp_yumi_i;

  bp_fe_fetch_tracker #(.vaddr_width_p(VA), .instr_width_p(IW), .latency_p(LAT), .fifo_els_p(FIFO)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .cmd_v_i(cmd_v_i), .cmd_vaddr_i(cmd_vaddr_i),
    .cmd_yumi_o(cmd_yumi_o), .cache_v_o(cache_v_o), .cache_ready_i(cache_ready_i),
    .cache_data_i(cache_data_i), .cache_data_v_i(cache_data_v_i), .itlb_miss_i(itlb_miss_i),
    .page_fault_i(page_fault_i), .access_fault_i(access_fault_i), .poison_i(poison_i),
    .flush_i(flush_i), .resp_v_o(resp_v_o), .resp_vaddr_o(resp_vaddr_o), .resp_data_o(resp_data_o),
    .resp_type_o(resp_type_o), .resp_yumi_i(resp_yumi_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [VA-1:0] va; int ic; } fetch_t;
  typedef struct { logic [VA-1:0] va; logic [IW-1:0] da; logic [2:0] ty; } resp_t;

  fetch_t mq_f[$];
  resp_t  mq_r[$];
  bit     m_wait;
  int     m_cyc;
  bit     pending;
  logic   e_y, e_rv;
  resp_t  e_hd;
  int     n_vec, n_miss;

  function automatic void model_reset();
    mq_f.delete(); mq_r.delete(); m_wait = 0; pending = 0;
  endfunction

  // Expected outputs for the current cycle's inputs.
  function automatic void model_eval();
    int cr;
    cr = mq_r.size();
    foreach (mq_f[i]) if (mq_f[i].ic < m_cyc) cr++;
    e_y  = cmd_v_i && cache_ready_i && !m_wait && !poison_i && !flush_i && (cr < FIFO);
    e_rv = (mq_r.size() > 0) && !flush_i;
    if (mq_r.size() > 0) e_hd = mq_r[0];
  endfunction

  // Apply the cycle that just ended at the clock edge.
  function automatic void model_commit();
    fetch_t nf;
    resp_t  r;
    int     fi;
    if (resp_yumi_i && e_rv) void'(mq_r.pop_front());
    if (e_y) begin nf.va = cmd_vaddr_i; nf.ic = m_cyc; mq_f.push_back(nf); end
    if (flush_i) begin
      mq_f.delete(); mq_r.delete(); m_wait = 0;
    end else if (poison_i) begin
      mq_f.delete();
    end else begin
      fi = -1;
      foreach (mq_f[i]) if (mq_f[i].ic == m_cyc - (LAT - 1)) fi = i;
      if (fi >= 0) begin
        r.va = mq_f[fi].va;
        r.ty = access_fault_i ? 3'd1 : page_fault_i ? 3'd2 : itlb_miss_i ? 3'd3 :
               !cache_data_v_i ? 3'd4 : 3'd0;
        r.da = (r.ty == 3'd0) ? cache_data_i : '0;
        mq_r.push_back(r);
        if (r.ty != 3'd0) begin m_wait = 1; mq_f.delete(); end
        else mq_f.delete(fi);
      end
    end
    m_cyc++;
  endfunction

  function automatic string obs_str();
    string s;
    s = $sformatf("yumi=%b cv=%b rv=%b", cmd_yumi_o, cache_v_o, resp_v_o);
    if (resp_v_o === 1'b1) s = {s, $sformatf(" va=%h d=%h t=%0d", resp_vaddr_o, resp_data_o, resp_type_o)};
    return s;
  endfunction

  function automatic string exp_str();
    string s;
    s = $sformatf("yumi=%b cv=%b rv=%b", e_y, e_y, e_rv);
    if (e_rv) s = {s, $sformatf(" va=%h d=%h t=%0d", e_hd.va, e_hd.da, e_hd.ty)};
    return s;
  endfunction

  task automatic drive(input logic cv, input logic [VA-1:0] va, input logic rdy, input logic dv,
                       input logic itlb, input logic pf, input logic af, input logic poi,
                       input logic fl, input logic want_y);
    @(negedge clk_i);
    if (pending) model_commit();
    cmd_v_i = cv; cmd_vaddr_i = va; cache_ready_i = rdy; cache_data_i = $urandom;
    cache_data_v_i = dv; itlb_miss_i = itlb; page_fault_i = pf; access_fault_i = af;
    poison_i = poi; flush_i = fl;
    model_eval();
    resp_yumi_i = want_y && (e_rv || fl);
    pending = 1;
    #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk_i);
    #1;
    n_vec++;
    if ({cmd_yumi_o, cache_v_o, resp_v_o} !== 3'b000) begin
      n_miss++; $display("FAIL reset_hold: got %b want 000", {cmd_yumi_o, cache_v_o, resp_v_o});
    end
    @(negedge clk_i);
    reset_i = 1'b0;
    model_reset();
    drive(0, '0, 1, 1, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs_str() != exp_str()) begin n_miss++; $display("FAIL reset_idle: got %s want %s", obs_str(), exp_str()); end
  endtask

  task automatic test_back_to_back();
    int first_iss = -1, first_rv = -1, last_rv = -1, nresp = 0;
    for (int i = 0; i < 12; i++) begin
      drive(i < 8, VA'(32'h1000 + 4 * i), 1, 1, 0, 0, 0, 0, 0, 1);
      n_vec++;
      if (obs_str() != exp_str()) begin n_miss++; $display("FAIL b2b c%0d: got %s want %s", i, obs_str(), exp_str()); end
      if (cmd_yumi_o === 1'b1 && first_iss < 0) first_iss = i;
      if (resp_v_o === 1'b1) begin
        if (first_rv < 0) first_rv = i;
        last_rv = i; nresp++;
        n_vec++;
        if (resp_type_o !== 3'd0) begin n_miss++; $display("FAIL b2b_type: got %0d want 0", resp_type_o); end
      end
    end
    n_vec++;
    if (first_rv - first_iss !== LAT) begin n_miss++; $display("FAIL b2b_latency: got %0d want %0d", first_rv - first_iss, LAT); end
    n_vec++;
    if (nresp !== 8 || last_rv - first_rv !== 7) begin
      n_miss++; $display("FAIL b2b_throughput: got %0d resps over %0d cycles want 8 over 8", nresp, last_rv - first_rv + 1);
    end
  endtask

  task automatic test_credits();
    int iss = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1, VA'(32'h4000 + 4 * iss), 1, 1, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if (obs_str() != exp_str()) begin n_miss++; $display("FAIL credit c%0d: got %s want %s", i, obs_str(), exp_str()); end
      if (cmd_yumi_o === 1'b1) iss++;
    end
    n_vec++;
    if (iss !== FIFO) begin n_miss++; $display("FAIL credit_limit: got %0d issued want %0d", iss, FIFO); end
    for (int i = 0; i < 4; i++) begin
      drive(1, VA'(32'h4000 + 4 * iss), 1, 1, 0, 0, 0, 0, 0, i == 0);
      n_vec++;
      if (obs_str() != exp_str()) begin n_miss++; $display("FAIL credit_rel c%0d: got %s want %s", i, obs_str(), exp_str()); end
      if (cmd_yumi_o === 1'b1) iss++;
    end
    n_vec++;
    if (iss !== FIFO + 1) begin n_miss++; $display("FAIL credit_release: got %0d issued want %0d", iss, FIFO + 1); end
    for (int i = 0; i < 8; i++) begin
      drive(0, '0, 1, 1, 0, 0, 0, 0, 0, 1);
      n_vec++;
      if (obs_str() != exp_str()) begin n_miss++; $display("FAIL credit_drain c%0d: got %s want %s", i, obs_str(), exp_str()); end
    end
  endtask

  task automatic test_exception();
    int iss = 0;
    drive(1, VA'(32'h2000), 1, 1, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (obs_str() != exp_str()) begin n_miss++; $display("FAIL exc_issue0: got %s want %s", obs_str(), exp_str()); end
    drive(1, VA'(32'h2004), 1, 1, 1, 1, 0, 0, 0, 0);
    n_vec++;
    if (obs_str() != exp_str()) begin n_miss++; $display("FAIL exc_issue1: got %s want %s", obs_str(), exp_str()); end
    for (int i = 0; i < 5; i++) begin
      drive(1, VA'(32'h2008), 1, 1, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if (obs_str() != exp_str()) begin n_miss++; $display("FAIL exc_wait c%0d: got %s want %s", i, obs_str(), exp_str()); end
      if (cmd_yumi_o === 1'b1) iss++;
    end
    n_vec++;
    if (resp_v_o !== 1'b1 || resp_type_o !== 3'd2 || resp_data_o !== '0 || resp_vaddr_o !== VA'(32'h2000)) begin
      n_miss++; $display("FAIL exc_resp: got v=%b t=%0d d=%h va=%h want v=1 t=2 d=0 va=2000",
                         resp_v_o, resp_type_o, resp_data_o, resp_vaddr_o);
    end
    n_vec++;
    if (iss !== 0) begin n_miss++; $display("FAIL exc_stall: got %0d issued want 0", iss); end
    drive(1, VA'(32'h2008), 1, 1, 0, 0, 0, 0, 0, 1);
    drive(1, VA'(32'h2008), 1, 1, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (resp_v_o !== 1'b0 || cmd_yumi_o !== 1'b0) begin
      n_miss++; $display("FAIL exc_younger_dropped: got rv=%b yumi=%b want 0 0", resp_v_o, cmd_yumi_o);
    end
    drive(1, VA'(32'h2008), 1, 1, 0, 0, 0, 0, 1, 0);
    n_vec++;
    if (cmd_yumi_o !== 1'b0) begin n_miss++; $display("FAIL exc_flush_cycle: got yumi=%b want 0", cmd_yumi_o); end
    drive(1, VA'(32'h2008), 1, 1, 0, 0, 0, 0, 0, 0);
    n_vec++;
    if (cmd_yumi_o !== 1'b1) begin n_miss++; $display("FAIL exc_resume: got yumi=%b want 1", cmd_yumi_o); end
    for (int i = 0; i < 4; i++) begin
      drive(0, '0, 1, 1, 0, 0, 0, 0, 0, 1);
      n_vec++;
      if (obs_str() != exp_str()) begin n_miss++; $display("FAIL exc_drain c%0d: got %s want %s", i, obs_str(), exp_str()); end
    end
  endtask

  task automatic test_poison();
    int iss = 0, nresp = 0;
    drive(1, VA'(32'h5000), 1, 1, 0, 0, 0, 0, 0, 0);
    drive(1, VA'(32'h5004), 1, 1, 0, 0, 0, 0, 0, 0);
    drive(1, VA'(32'h5008), 1, 1, 0, 0, 0, 1, 0, 0);
    n_vec++;
    if (obs_str() != exp_str()) begin n_miss++; $display("FAIL poison_cycle: got %s want %s", obs_str(), exp_str()); end
    for (int i = 0; i < 6; i++) begin
      drive(1, VA'(32'h500c + 4 * iss), 1, 1, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if (obs_str() != exp_str()) begin n_miss++; $display("FAIL poison_refill c%0d: got %s want %s", i, obs_str(), exp_str()); end
      if (cmd_yumi_o === 1'b1) iss++;
    end
    n_vec++;
    if (iss !== FIFO - 1 || resp_vaddr_o !== VA'(32'h5000)) begin
      n_miss++; $display("FAIL poison_credits: got %0d issued head %h want %0d head 5000", iss, resp_vaddr_o, FIFO - 1);
    end
    for (int i = 0; i < 8; i++) begin
      drive(0, '0, 1, 1, 0, 0, 0, 0, 0, 1);
      n_vec++;
      if (obs_str() != exp_str()) begin n_miss++; $display("FAIL poison_drain c%0d: got %s want %s", i, obs_str(), exp_str()); end
      if (resp_v_o === 1'b1) nresp++;
    end
    n_vec++;
    if (nresp !== FIFO) begin n_miss++; $display("FAIL poison_count: got %0d resps want %0d", nresp, FIFO); end
  endtask

  task automatic test_flush();
    int iss = 0;
    drive(1, VA'(32'h6000), 1, 1, 0, 0, 0, 0, 0, 0);
    drive(1, VA'(32'h6004), 1, 1, 0, 0, 0, 0, 0, 0);
    drive(1, VA'(32'h6008), 1, 1, 0, 0, 0, 0, 0, 0);
    drive(0, '0, 1, 1, 0, 1, 0, 0, 1, 1);
    n_vec++;
    if (resp_v_o !== 1'b0) begin n_miss++; $display("FAIL flush_rv: got %b want 0", resp_v_o); end
    for (int i = 0; i < 6; i++) begin
      drive(1, VA'(32'h6100 + 4 * iss), 1, 1, 0, 0, 0, 0, 0, 0);
      n_vec++;
      if (obs_str() != exp_str()) begin n_miss++; $display("FAIL flush_after c%0d: got %s want %s", i, obs_str(), exp_str()); end
      if (i == 0) begin
        n_vec++;
        if (resp_v_o !== 1'b0 || cmd_yumi_o !== 1'b1) begin
          n_miss++; $display("FAIL flush_empty: got rv=%b yumi=%b want 0 1", resp_v_o, cmd_yumi_o);
        end
      end
      if (cmd_yumi_o === 1'b1) iss++;
    end
    n_vec++;
    if (iss !== FIFO) begin n_miss++; $display("FAIL flush_credits: got %0d issued want %0d", iss, FIFO); end
    for (int i = 0; i < 8; i++) begin
      drive(0, '0, 1, 1, 0, 0, 0, 0, 0, 1);
      n_vec++;
      if (obs_str() != exp_str()) begin n_miss++; $display("FAIL flush_drain c%0d: got %s want %s", i, obs_str(), exp_str()); end
    end
  endtask

  task automatic test_async_reset();
    int nok = 0;
    for (int i = 0; i < 3; i++) begin
      drive(1, VA'(32'h7000 + 4 * i), 1, 1, 0, 0, 0, 0, 0, 1);
      n_vec++;
      if (obs_str() != exp_str()) begin n_miss++; $display("FAIL arst_burst c%0d: got %s want %s", i, obs_str(), exp_str()); end
    end
    #2;
    reset_i = 1'b1;
    #1;
    n_vec++;
    if (resp_v_o !== 1'b0 || cmd_yumi_o !== 1'b0) begin
      n_miss++; $display("FAIL arst_immediate: got rv=%b yumi=%b want 0 0", resp_v_o, cmd_yumi_o);
    end
    model_reset();
    cmd_v_i = 0; resp_yumi_i = 0; poison_i = 0; flush_i = 0;
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(i == 0, VA'(32'h3000), 1, 1, 0, 0, 0, 0, 0, 1);
      n_vec++;
      if (obs_str() != exp_str()) begin n_miss++; $display("FAIL arst_after c%0d: got %s want %s", i, obs_str(), exp_str()); end
      if (resp_v_o === 1'b1 && resp_vaddr_o === VA'(32'h3000) && resp_type_o === 3'd0) nok++;
    end
    n_vec++;
    if (nok !== 1) begin n_miss++; $display("FAIL arst_fetch: got %0d OK resps for 3000 want 1", nok); end
  endtask

  task automatic test_random();
    logic [VA-1:0] va;
    for (int i = 0; i < 400; i++) begin
      va = {$urandom, $urandom};
      drive($urandom_range(3, 0) != 0, va, $urandom_range(4, 0) != 0, $urandom_range(5, 0) != 0,
            $urandom_range(19, 0) == 0, $urandom_range(24, 0) == 0, $urandom_range(29, 0) == 0,
            $urandom_range(24, 0) == 0, m_wait ? ($urandom_range(3, 0) == 0) : ($urandom_range(39, 0) == 0),
            $urandom_range(2, 0) != 0);
      n_vec++;
      if (obs_str() != exp_str()) begin n_miss++; $display("FAIL random c%0d: got %s want %s", i, obs_str(), exp_str()); end
    end
  endtask

  initial begin
    n_vec = 0; n_miss = 0; m_cyc = 0; pending = 0; m_wait = 0;
    reset_i = 1'b1; cmd_v_i = 0; cmd_vaddr_i = '0; cache_ready_i = 0; cache_data_i = '0;
    cache_data_v_i = 0; itlb_miss_i = 0; page_fault_i = 0; access_fault_i = 0;
    poison_i = 0; flush_i = 0; resp_yumi_i = 0;
    test_reset();
    test_back_to_back();
    test_credits();
    test_exception();
    test_poison();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
